// File: rtl/cpu_pkg.sv
// Shared definitions for the accumulator CPU sequencer: opcodes, cycle
// states and the bundle of control strobes driven into the datapath.
package cpu_pkg;

    // Opcode field of the instruction register.
    typedef enum logic [2:0] {
        HLT  = 3'd0,
        SKZ  = 3'd1,
        ADD  = 3'd2,
        ANDD = 3'd3,
        XORR = 3'd4,
        LDA  = 3'd5,
        STO  = 3'd6,
        JMP  = 3'd7
    } opcode_t;

    // Instruction-cycle states; S0..S7 form the fixed fetch/execute cycle.
    typedef enum logic [3:0] {
        IDLE = 4'd0,
        S0   = 4'd1,
        S1   = 4'd2,
        S2   = 4'd3,
        S3   = 4'd4,
        S4   = 4'd5,
        S5   = 4'd6,
        S6   = 4'd7,
        S7   = 4'd8,
        HALT = 4'd9
    } state_t;

    // One bit per datapath control output.
    typedef struct packed {
        logic rd;
        logic wr;
        logic load_ir;
        logic inc_pc;
        logic load_pc;
        logic alu_ena;
        logic load_acc;
        logic datactl_ena;
        logic halt;
    } strobe_t;

    localparam strobe_t STROBE_NONE = '0;

    // Opcodes that read an operand from memory and update the accumulator.
    function automatic logic is_alu_op(input opcode_t op);
        return (op == ADD) || (op == ANDD) || (op == XORR) || (op == LDA);
    endfunction

endpackage

// File: rtl/cpu_seq_decode.sv
// Combinational strobe decode: maps the state being entered, together with
// the captured opcode and zero flag, onto the datapath control strobes.
module cpu_seq_decode
    import cpu_pkg::*;
(
    input  state_t  next_state,
    input  opcode_t op,
    input  logic    zero_flag,
    output strobe_t strobes
);

    // Strobes for the state about to be entered.
    always_comb begin
        // NOTE: assigning every output a default first keeps this block free of inferred latches.
        strobes = STROBE_NONE;
        case (next_state)
            S0, S1: begin
                // Fetch: read the two instruction bytes and step the PC.
                strobes.rd      = 1'b1;
                strobes.load_ir = 1'b1;
                strobes.inc_pc  = 1'b1;
            end
            S3, S4: begin
                if (is_alu_op(op)) begin
                    // Operand read; ALU register in S3, accumulator in S4.
                    strobes.rd       = 1'b1;
                    strobes.alu_ena  = (next_state == S3);
                    strobes.load_acc = (next_state == S4);
                end else begin
                    case (op)
                        STO: begin
                            strobes.datactl_ena = 1'b1;
                            strobes.wr          = (next_state == S4);
                        end
                        JMP:     strobes.load_pc = 1'b1;
                        SKZ:     strobes.inc_pc  = zero_flag;
                        default: ;
                    endcase
                end
            end
            // Keep the accumulator on the bus one cycle past the write.
            S5:      strobes.datactl_ena = (op == STO);
            HALT:    strobes.halt        = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: rtl/cpu_sequencer.sv
// Instruction-cycle controller: steps each instruction through S0..S7,
// captures opcode/zero mid-cycle and registers the decoded strobes so every
// output is stable for the whole state it belongs to.
module cpu_sequencer
    import cpu_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       ena,
    input  logic [2:0] opcode,
    input  logic       zero,
    output logic       rd,
    output logic       wr,
    output logic       load_ir,
    output logic       inc_pc,
    output logic       load_pc,
    output logic       alu_ena,
    output logic       load_acc,
    output logic       datactl_ena,
    output logic       halt
);

    state_t  state;
    state_t  next_state;
    opcode_t op_q;
    opcode_t op_d;
    logic    zero_q;
    logic    zero_d;
    strobe_t strobes_d;
    strobe_t strobes_q;

    // Next-state logic for the fetch/execute cycle.
    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (ena) next_state = S0;
            S0:      next_state = S1;
            S1:      next_state = S2;
            S2:      next_state = S3;
            S3:      next_state = (op_q == HLT) ? HALT : S4;
            S4:      next_state = S5;
            S5:      next_state = S6;
            S6:      next_state = S7;
            S7:      next_state = ena ? S0 : IDLE;
            HALT:    next_state = HALT;
            default: next_state = IDLE;
        endcase
    end

    // Opcode/zero capture on the S2->S3 edge; the decode sees the value
    // being captured so S3 strobes are correct on that same edge.
    always_comb begin
        op_d   = op_q;
        zero_d = zero_q;
        if (state == S2) begin
            op_d   = opcode_t'(opcode);
            zero_d = zero;
        end
    end

    cpu_seq_decode u_decode (
        .next_state (next_state),
        .op         (op_d),
        .zero_flag  (zero_d),
        .strobes    (strobes_d)
    );

    // State, captured instruction fields and registered strobes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            op_q      <= HLT;
            zero_q    <= 1'b0;
            strobes_q <= STROBE_NONE;
        end else begin
            // NOTE: non-blocking assignments here so every register samples pre-edge values.
            state     <= next_state;
            op_q      <= op_d;
            zero_q    <= zero_d;
            strobes_q <= strobes_d;
        end
    end

    assign rd          = strobes_q.rd;
    assign wr          = strobes_q.wr;
    assign load_ir     = strobes_q.load_ir;
    assign inc_pc      = strobes_q.inc_pc;
    assign load_pc     = strobes_q.load_pc;
    assign alu_ena     = strobes_q.alu_ena;
    assign load_acc    = strobes_q.load_acc;
    assign datactl_ena = strobes_q.datactl_ena;
    assign halt        = strobes_q.halt;

endmodule

// File: tb/tb_cpu_sequencer.sv
// Self-checking bench for cpu_sequencer: a table of instructions run
// back-to-back through a per-cycle expected-strobe queue, plus hand-written
// sequences for reset mid-STO, ena dropped mid-instruction and HLT.
module tb_cpu_sequencer;
    import cpu_pkg::*;

    // Strobe bit positions in the observed vector.
    localparam logic [8:0] B_RD    = 9'h100;
    localparam logic [8:0] B_WR    = 9'h080;
    localparam logic [8:0] B_IR    = 9'h040;
    localparam logic [8:0] B_INC   = 9'h020;
    localparam logic [8:0] B_LPC   = 9'h010;
    localparam logic [8:0] B_ALU   = 9'h008;
    localparam logic [8:0] B_ACC   = 9'h004;
    localparam logic [8:0] B_DCTL  = 9'h002;
    localparam logic [8:0] B_HALT  = 9'h001;
    localparam logic [8:0] FETCH   = B_RD | B_IR | B_INC;
    localparam logic [8:0] NONE    = 9'h000;

    logic       clk = 1'b0;
    logic       rst;
    logic       ena;
    logic [2:0] opcode;
    logic       zero;
    logic       rd, wr, load_ir, inc_pc, load_pc, alu_ena, load_acc, datactl_ena, halt;
    logic [8:0] obs;

    int n_checks = 0;
    int n_errors = 0;

    logic [8:0] sb_q [$];

    typedef struct {
        string      name;
        logic [2:0] op;
        logic       z;
        logic       tog;
        logic [8:0] s3;
        logic [8:0] s4;
        logic [8:0] s5;
        int         incs;
    } vec_t;

    vec_t vecs [11];

    cpu_sequencer dut (
        .clk         (clk),
        .rst         (rst),
        .ena         (ena),
        .opcode      (opcode),
        .zero        (zero),
        .rd          (rd),
        .wr          (wr),
        .load_ir     (load_ir),
        .inc_pc      (inc_pc),
        .load_pc     (load_pc),
        .alu_ena     (alu_ena),
        .load_acc    (load_acc),
        .datactl_ena (datactl_ena),
        .halt        (halt)
    );

    always #5 clk = ~clk;

    assign obs = {rd, wr, load_ir, inc_pc, load_pc, alu_ena, load_acc, datactl_ena, halt};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Advance one clock and sample away from the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Run one full instruction from the edge entering S0 through S7.
    task automatic run_instr(input vec_t v);
        int incs;
        logic [8:0] e;
        incs   = 0;
        opcode = v.op;
        zero   = v.z;
        sb_q.push_back(FETCH);
        sb_q.push_back(FETCH);
        sb_q.push_back(NONE);
        sb_q.push_back(v.s3);
        sb_q.push_back(v.s4);
        sb_q.push_back(v.s5);
        sb_q.push_back(NONE);
        sb_q.push_back(NONE);
        for (int k = 0; k < 8; k++) begin
            step();
            e = sb_q.pop_front();
            check($sformatf("%s cycle%0d strobes", v.name, k + 1), 32'(obs), 32'(e));
            check($sformatf("%s cycle%0d exclusive", v.name, k + 1),
                  {30'd0, rd & wr, load_pc & inc_pc}, 32'd0);
            incs += int'(inc_pc);
            // Flip zero inside S3/S4; the captured flag must not follow it.
            if (v.tog && (k == 3 || k == 4)) zero = ~zero;
        end
        check($sformatf("%s inc_pc count", v.name), 32'(incs), 32'(v.incs));
    endtask

    initial begin
        vecs[0]  = '{name:"lda",      op:3'd5, z:1'b0, tog:1'b0, s3:B_RD|B_ALU, s4:B_RD|B_ACC, s5:NONE,   incs:2};
        vecs[1]  = '{name:"add",      op:3'd2, z:1'b1, tog:1'b0, s3:B_RD|B_ALU, s4:B_RD|B_ACC, s5:NONE,   incs:2};
        vecs[2]  = '{name:"andd",     op:3'd3, z:1'b0, tog:1'b0, s3:B_RD|B_ALU, s4:B_RD|B_ACC, s5:NONE,   incs:2};
        vecs[3]  = '{name:"xorr",     op:3'd4, z:1'b1, tog:1'b0, s3:B_RD|B_ALU, s4:B_RD|B_ACC, s5:NONE,   incs:2};
        vecs[4]  = '{name:"sto",      op:3'd6, z:1'b0, tog:1'b0, s3:B_DCTL,     s4:B_DCTL|B_WR, s5:B_DCTL, incs:2};
        vecs[5]  = '{name:"jmp",      op:3'd7, z:1'b1, tog:1'b0, s3:B_LPC,      s4:B_LPC,      s5:NONE,   incs:2};
        vecs[6]  = '{name:"skz_z1",   op:3'd1, z:1'b1, tog:1'b0, s3:B_INC,      s4:B_INC,      s5:NONE,   incs:4};
        vecs[7]  = '{name:"skz_z0",   op:3'd1, z:1'b0, tog:1'b0, s3:NONE,       s4:NONE,       s5:NONE,   incs:2};
        vecs[8]  = '{name:"skz_z1_t", op:3'd1, z:1'b1, tog:1'b1, s3:B_INC,      s4:B_INC,      s5:NONE,   incs:4};
        vecs[9]  = '{name:"skz_z0_t", op:3'd1, z:1'b0, tog:1'b1, s3:NONE,       s4:NONE,       s5:NONE,   incs:2};
        vecs[10] = '{name:"sto_z1",   op:3'd6, z:1'b1, tog:1'b0, s3:B_DCTL,     s4:B_DCTL|B_WR, s5:B_DCTL, incs:2};

        rst    = 1'b1;
        ena    = 1'b0;
        opcode = 3'd5;
        zero   = 1'b1;
        repeat (2) step();
        check("reset outputs", 32'(obs), 32'(NONE));
        check("reset state", 32'(dut.state), 32'(IDLE));
        check("reset op_q", 32'(dut.op_q), 32'(HLT));
        check("reset zero_q", 32'(dut.zero_q), 32'd0);

        @(negedge clk);
        rst = 1'b0;
        step();
        check("idle hold ena=0", 32'(obs), 32'(NONE));

        // Back-to-back table; first S0 one clock after ena rises in IDLE.
        @(negedge clk);
        ena = 1'b1;
        for (int i = 0; i < 11; i++) run_instr(vecs[i]);
        ena = 1'b0;
        step();
        check("idle after table", 32'(obs), 32'(NONE));
        check("idle state after table", 32'(dut.state), 32'(IDLE));

        // ena dropped during S5 of an LDA: finishes through S7, then IDLE.
        ena    = 1'b1;
        opcode = 3'd5;
        zero   = 1'b0;
        step();
        check("drop s0", 32'(obs), 32'(FETCH));
        step();
        check("drop s1", 32'(obs), 32'(FETCH));
        step();
        check("drop s2", 32'(obs), 32'(NONE));
        step();
        check("drop s3", 32'(obs), 32'(B_RD | B_ALU));
        step();
        check("drop s4", 32'(obs), 32'(B_RD | B_ACC));
        step();
        ena = 1'b0;
        check("drop s5", 32'(obs), 32'(NONE));
        step();
        check("drop s6", 32'(obs), 32'(NONE));
        step();
        check("drop s7", 32'(obs), 32'(NONE));
        step();
        check("drop idle", 32'(obs), 32'(NONE));
        check("drop idle state", 32'(dut.state), 32'(IDLE));
        step();
        check("drop idle hold", 32'(obs), 32'(NONE));
        ena = 1'b1;
        step();
        check("restart s0 latency", 32'(obs), 32'(FETCH));

        // STO follows; assert rst mid-S4 and expect wr to drop with no edge.
        opcode = 3'd6;
        step();
        check("sto s1", 32'(obs), 32'(FETCH));
        step();
        check("sto s2", 32'(obs), 32'(NONE));
        step();
        check("sto s3", 32'(obs), 32'(B_DCTL));
        step();
        check("sto s4", 32'(obs), 32'(B_DCTL | B_WR));
        #2;
        rst = 1'b1;
        #1;
        check("async reset wr/dctl", 32'(obs), 32'(NONE));
        check("async reset state", 32'(dut.state), 32'(IDLE));
        @(negedge clk);
        ena = 1'b0;
        rst = 1'b0;
        step();
        check("post reset idle", 32'(obs), 32'(NONE));
        check("post reset state", 32'(dut.state), 32'(IDLE));

        // HLT: halt rises on the edge leaving S3 and holds regardless of ena.
        ena    = 1'b1;
        opcode = 3'd0;
        step();
        check("hlt s0", 32'(obs), 32'(FETCH));
        step();
        check("hlt s1", 32'(obs), 32'(FETCH));
        step();
        check("hlt s2", 32'(obs), 32'(NONE));
        step();
        check("hlt s3", 32'(obs), 32'(NONE));
        step();
        check("hlt enter", 32'(obs), 32'(B_HALT));
        for (int i = 0; i < 22; i++) begin
            ena    = 1'($urandom_range(0, 1));
            opcode = 3'($urandom_range(0, 7));
            zero   = 1'($urandom_range(0, 1));
            step();
            check($sformatf("hlt hold %0d", i), 32'(obs), 32'(B_HALT));
        end
        rst = 1'b1;
        #1;
        check("hlt cleared by reset", 32'(obs), 32'(NONE));
        @(negedge clk);
        rst = 1'b0;
        ena = 1'b0;
        step();
        check("hlt post reset idle", 32'(obs), 32'(NONE));

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
